// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control FSM: opcodes, ALU control words
// and the controller state encoding.
// Optional feature macro: ILLEGAL_TRAP_EN adds the TRAP state.
package alu_ctrl_pkg;

    // Instruction opcodes (instr[15:12]); 7..15 are illegal
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_ADDI = 4'd3;
    localparam logic [3:0] OP_LW   = 4'd4;
    localparam logic [3:0] OP_SW   = 4'd5;
    localparam logic [3:0] OP_BEQ  = 4'd6;

    // ALU control encodings
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

`ifdef ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {ST_IDLE, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_DECODE, ST_EXEC, ST_MEM, ST_WB} state_t;
`endif

endpackage

// File: rtl/alu_ctrl_fsm_if.sv
// Instruction, register-file, ALU and memory signals of the ALU control FSM.
// master: the controller; slave: its environment (fetch, regfile, ALU, memory).
// Optional feature macro: ILLEGAL_TRAP_EN adds the illegal_op flag.
interface alu_ctrl_fsm_if #(
    parameter int DATA_W = 16
);
    logic              instr_valid;
    logic [15:0]       instr;
    logic              instr_ready;
    logic [3:0]        rs_addr;
    logic [3:0]        rt_addr;
    logic [3:0]        rd_addr;
    logic [3:0]        ALU_CTRL;
    logic              alu_src_imm;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] alu_result;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic              mem_ack;
    logic              reg_we;
    logic              done;
    logic              branch_taken;
    logic              mem_err;
`ifdef ILLEGAL_TRAP_EN
    logic              illegal_op;
`endif

    modport master (
        input  instr_valid, instr, alu_result, mem_ack,
        output instr_ready, rs_addr, rt_addr, rd_addr, ALU_CTRL, alu_src_imm, imm,
               mem_req, mem_we, mem_addr, reg_we, done, branch_taken, mem_err
`ifdef ILLEGAL_TRAP_EN
        , output illegal_op
`endif
    );

    modport slave (
        output instr_valid, instr, alu_result, mem_ack,
        input  instr_ready, rs_addr, rt_addr, rd_addr, ALU_CTRL, alu_src_imm, imm,
               mem_req, mem_we, mem_addr, reg_we, done, branch_taken, mem_err
`ifdef ILLEGAL_TRAP_EN
        , input illegal_op
`endif
    );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode decoder: ALU control word plus instruction class flags.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [3:0] i_opcode,
    output logic [3:0] o_alu_ctrl,
    output logic       o_alu_src_imm,
    output logic       o_is_mem,
    output logic       o_is_wr,
    output logic       o_is_branch,
    output logic       o_illegal
);

    // Map each opcode to its control word; unknown opcodes flag illegal
    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        o_alu_ctrl    = ALU_ADD;
        o_alu_src_imm = 1'b0;
        o_is_mem      = 1'b0;
        o_is_wr       = 1'b0;
        o_is_branch   = 1'b0;
        o_illegal     = 1'b0;
        case (i_opcode)
            OP_ADD:  o_is_wr = 1'b1;
            OP_SUB:  begin o_alu_ctrl = ALU_SUB; o_is_wr = 1'b1; end
            OP_SLT:  begin o_alu_ctrl = ALU_SLT; o_is_wr = 1'b1; end
            OP_ADDI: begin o_alu_src_imm = 1'b1; o_is_wr = 1'b1; end
            OP_LW:   begin o_alu_src_imm = 1'b1; o_is_mem = 1'b1; o_is_wr = 1'b1; end
            OP_SW:   begin o_alu_src_imm = 1'b1; o_is_mem = 1'b1; end
            OP_BEQ:  begin o_alu_ctrl = ALU_SUB; o_is_branch = 1'b1; end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle ALU/memory instruction controller:
// IDLE -> DECODE -> EXEC -> (WB | MEM -> WB/IDLE | IDLE).
// Optional feature macro: ILLEGAL_TRAP_EN -- illegal opcodes lock up in TRAP
// with illegal_op set until reset; otherwise they retire as a NOP.
module alu_ctrl_fsm
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    alu_ctrl_fsm_if.master bus
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    logic [3:0]        r_opcode;
    logic              r_instr_ready;
    logic [3:0]        r_rs_addr;
    logic [3:0]        r_rt_addr;
    logic [3:0]        r_rd_addr;
    logic [DATA_W-1:0] r_imm;
    logic [3:0]        r_alu_ctrl;
    logic              r_alu_src_imm;
    logic [DATA_W-1:0] r_mem_addr;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [CNT_W-1:0]  r_mem_cnt;
    logic              r_reg_we;
    logic              r_done;
    logic              r_branch_eval;
    logic              r_mem_err;
`ifdef ILLEGAL_TRAP_EN
    logic              r_illegal_op;
`endif

    logic [3:0] w_alu_ctrl;
    logic       w_alu_src_imm;
    logic       w_is_mem;
    logic       w_is_wr;
    logic       w_is_branch;
    logic       w_illegal;
    logic       w_alu_zero;

    alu_ctrl_decode u_decode (
        .i_opcode      (r_opcode),
        .o_alu_ctrl    (w_alu_ctrl),
        .o_alu_src_imm (w_alu_src_imm),
        .o_is_mem      (w_is_mem),
        .o_is_wr       (w_is_wr),
        .o_is_branch   (w_is_branch),
        .o_illegal     (w_illegal)
    );

    // Controller state machine with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_opcode      <= '0;
            r_instr_ready <= 1'b1;
            r_rs_addr     <= '0;
            r_rt_addr     <= '0;
            r_rd_addr     <= '0;
            r_imm         <= '0;
            r_alu_ctrl    <= ALU_ADD;
            r_alu_src_imm <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_cnt     <= '0;
            r_reg_we      <= 1'b0;
            r_done        <= 1'b0;
            r_branch_eval <= 1'b0;
            r_mem_err     <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            r_illegal_op  <= 1'b0;
`endif
        end else begin
            // NOTE: pulses default low with non-blocking assignments; a later
            // assignment in the same pass overrides, so each pulse lasts one cycle.
            r_reg_we      <= 1'b0;
            r_done        <= 1'b0;
            r_branch_eval <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        r_opcode      <= bus.instr[15:12];
                        r_rd_addr     <= bus.instr[11:8];
                        r_rs_addr     <= bus.instr[7:4];
                        r_rt_addr     <= bus.instr[3:0];
                        r_imm         <= {{(DATA_W-4){bus.instr[3]}}, bus.instr[3:0]};
                        r_instr_ready <= 1'b0;
                        r_state       <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_alu_ctrl    <= w_alu_ctrl;
                    r_alu_src_imm <= w_alu_src_imm;
                    r_state       <= ST_EXEC;
                    // Branches and NOPs retire during EXEC, so their done is armed here
                    if (w_is_branch) begin
                        r_done        <= 1'b1;
                        r_branch_eval <= 1'b1;
                    end
`ifndef ILLEGAL_TRAP_EN
                    else if (w_illegal) begin
                        r_done <= 1'b1;
                    end
`endif
                end
                ST_EXEC: begin
                    r_mem_addr <= bus.alu_result;
                    r_alu_ctrl <= ALU_ADD;
                    r_mem_cnt  <= '0;
                    if (w_illegal) begin
`ifdef ILLEGAL_TRAP_EN
                        r_illegal_op  <= 1'b1;
                        r_state       <= ST_TRAP;
`else
                        r_instr_ready <= 1'b1;
                        r_state       <= ST_IDLE;
`endif
                    end else if (w_is_branch) begin
                        r_instr_ready <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else if (w_is_mem) begin
                        r_mem_req <= 1'b1;
                        r_mem_we  <= ~w_is_wr;
                        r_state   <= ST_MEM;
                    end else begin
                        r_reg_we <= 1'b1;
                        r_done   <= 1'b1;
                        r_state  <= ST_WB;
                    end
                end
                ST_MEM: begin
                    // An ack in the final timeout cycle takes priority over the timeout
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_done    <= 1'b1;
                        if (w_is_wr) begin
                            r_reg_we <= 1'b1;
                            r_state  <= ST_WB;
                        end else begin
                            r_instr_ready <= 1'b1;
                            r_state       <= ST_IDLE;
                        end
                    end else if (r_mem_cnt == CNT_LAST) begin
                        r_mem_req     <= 1'b0;
                        r_mem_we      <= 1'b0;
                        r_mem_err     <= 1'b1;
                        r_done        <= 1'b1;
                        r_instr_ready <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_mem_cnt <= r_mem_cnt + 1'b1;
                    end
                end
                ST_WB: begin
                    r_instr_ready <= 1'b1;
                    r_state       <= ST_IDLE;
                end
`ifdef ILLEGAL_TRAP_EN
                ST_TRAP: r_state <= ST_TRAP;
`endif
                default: begin
                    r_instr_ready <= 1'b1;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    // BEQ resolves on the ALU result present during EXEC, alongside its done pulse
    assign w_alu_zero = (bus.alu_result == '0);

    assign bus.instr_ready  = r_instr_ready;
    assign bus.rs_addr      = r_rs_addr;
    assign bus.rt_addr      = r_rt_addr;
    assign bus.rd_addr      = r_rd_addr;
    assign bus.imm          = r_imm;
    assign bus.ALU_CTRL     = r_alu_ctrl;
    assign bus.alu_src_imm  = r_alu_src_imm;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_req      = r_mem_req;
    assign bus.mem_we       = r_mem_we;
    assign bus.reg_we       = r_reg_we;
    assign bus.done         = r_done;
    assign bus.branch_taken = r_branch_eval & w_alu_zero;
    assign bus.mem_err      = r_mem_err;
`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal_op   = r_illegal_op;
`endif

endmodule
